// File: rtl/mpt_fetch_arbiter.sv
// Multi-channel MPT walk fetch stage: round-robin arbitration, SPA format check, output FIFO, flush.
// Optional fault counter (fault_cnt_o / fault_cnt_clr_i) enabled by defining MPT_FETCH_FAULT_CNT_EN.
module mpt_fetch_arbiter #(
  parameter  int NUM_CH = 4,
  parameter  int DEPTH  = 4,
  parameter  int TAG_W  = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_CH-1:0]       req_valid_i,
  output logic [NUM_CH-1:0]       req_ready_o,
  input  logic [NUM_CH*4-1:0]     req_mode_i,
  input  logic [NUM_CH*64-1:0]    req_spa_i,
  input  logic [NUM_CH*TAG_W-1:0] req_tag_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [63:0]             out_spa_o,
  output logic [3:0]              out_mode_o,
  output logic [TAG_W-1:0]        out_tag_o,
  output logic [CH_W-1:0]         out_chan_o,
  output logic                    out_walk_o,
  output logic                    out_fault_o,
`ifdef MPT_FETCH_FAULT_CNT_EN
  output logic [15:0]             fault_cnt_o,
  input  logic                    fault_cnt_clr_i,
`endif
  input  logic                    flush_i,
  output logic                    flush_done_o,
  output logic [AW:0]             fifo_count_o
);

  logic [3:0]       mode_arr [NUM_CH];
  logic [63:0]      spa_arr  [NUM_CH];
  logic [TAG_W-1:0] tag_arr  [NUM_CH];

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      mode_arr[c] = req_mode_i[c*4 +: 4];
      spa_arr[c]  = req_spa_i[c*64 +: 64];
      tag_arr[c]  = req_tag_i[c*TAG_W +: TAG_W];
    end
  end

  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] grant;
  logic            found;
  logic [CH_W:0]   idx_w;

  // Scan from rr_ptr upward, wrapping modulo NUM_CH; first valid channel wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx_w = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx_w = {1'b0, rr_ptr} + (CH_W+1)'(i);
      if (idx_w >= (CH_W+1)'(NUM_CH))
        idx_w = idx_w - (CH_W+1)'(NUM_CH);
      if (!found && req_valid_i[idx_w[CH_W-1:0]]) begin
        found = 1'b1;
        grant = idx_w[CH_W-1:0];
      end
    end
  end

  logic [3:0]       g_mode;
  logic [63:0]      g_spa;
  logic [TAG_W-1:0] g_tag;
  logic             g_fault;

  assign g_mode = mode_arr[grant];
  assign g_spa  = spa_arr[grant];
  assign g_tag  = tag_arr[grant];

  always_comb begin
    case (g_mode)
      4'd1:    g_fault = |g_spa[63:43];
      4'd2:    g_fault = |g_spa[63:52];
      4'd3:    g_fault = 1'b0;
      default: g_fault = 1'b1;
    endcase
  end

  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, push, pop;

  assign fifo_count_o = wr_ptr - rd_ptr;
  assign out_valid_o  = (fifo_count_o != '0);
  assign full         = fifo_count_o[AW];
  assign push         = found && !full && !flush_i;
  assign pop          = out_valid_o && out_ready_i && !flush_i;

  always_comb begin
    req_ready_o = '0;
    if (push)
      req_ready_o[grant] = 1'b1;
  end

  logic [63:0]      spa_mem   [DEPTH];
  logic [3:0]       mode_mem  [DEPTH];
  logic [TAG_W-1:0] tag_mem   [DEPTH];
  logic [CH_W-1:0]  chan_mem  [DEPTH];
  logic             walk_mem  [DEPTH];
  logic             fault_mem [DEPTH];

  // Entries are cleared on reset so the head fields read zero until the first push.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rr_ptr       <= '0;
      flush_done_o <= 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
        spa_mem[e]   <= '0;
        mode_mem[e]  <= '0;
        tag_mem[e]   <= '0;
        chan_mem[e]  <= '0;
        walk_mem[e]  <= 1'b0;
        fault_mem[e] <= 1'b0;
      end
    end else begin
      flush_done_o <= flush_i;
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        rr_ptr <= '0;
      end else begin
        if (push) begin
          spa_mem[wr_ptr[AW-1:0]]   <= g_spa;
          mode_mem[wr_ptr[AW-1:0]]  <= g_mode;
          tag_mem[wr_ptr[AW-1:0]]   <= g_tag;
          chan_mem[wr_ptr[AW-1:0]]  <= grant;
          walk_mem[wr_ptr[AW-1:0]]  <= !g_fault;
          fault_mem[wr_ptr[AW-1:0]] <= g_fault;
          wr_ptr <= wr_ptr + 1'b1;
          rr_ptr <= (grant == CH_W'(NUM_CH-1)) ? '0 : grant + 1'b1;
        end
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign out_spa_o   = spa_mem[rd_ptr[AW-1:0]];
  assign out_mode_o  = mode_mem[rd_ptr[AW-1:0]];
  assign out_tag_o   = tag_mem[rd_ptr[AW-1:0]];
  assign out_chan_o  = chan_mem[rd_ptr[AW-1:0]];
  assign out_walk_o  = walk_mem[rd_ptr[AW-1:0]];
  assign out_fault_o = fault_mem[rd_ptr[AW-1:0]];

`ifdef MPT_FETCH_FAULT_CNT_EN
  // Clear beats a same-cycle increment; flush leaves the count alone.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      fault_cnt_o <= '0;
    else if (fault_cnt_clr_i)
      fault_cnt_o <= '0;
    else if (push && g_fault && fault_cnt_o != 16'hFFFF)
      fault_cnt_o <= fault_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mpt_fetch_arbiter.sv
// Self-checking bench for mpt_fetch_arbiter: format-check vector table, round-robin/full/flush/reset
// sequences, and a reference model with an expected-entry scoreboard.
module tb_mpt_fetch_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [3:0]   req_valid_i;
  logic [3:0]   req_ready_o;
  logic [15:0]  req_mode_i;
  logic [255:0] req_spa_i;
  logic [31:0]  req_tag_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [63:0]  out_spa_o;
  logic [3:0]   out_mode_o;
  logic [7:0]   out_tag_o;
  logic [1:0]   out_chan_o;
  logic         out_walk_o;
  logic         out_fault_o;
  logic         flush_i;
  logic         flush_done_o;
  logic [2:0]   fifo_count_o;
`ifdef MPT_FETCH_FAULT_CNT_EN
  logic [15:0]  fault_cnt_o;
  logic         fault_cnt_clr_i;
`endif

  mpt_fetch_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_mode_i(req_mode_i), .req_spa_i(req_spa_i), .req_tag_i(req_tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_spa_o(out_spa_o), .out_mode_o(out_mode_o), .out_tag_o(out_tag_o),
    .out_chan_o(out_chan_o), .out_walk_o(out_walk_o), .out_fault_o(out_fault_o),
`ifdef MPT_FETCH_FAULT_CNT_EN
    .fault_cnt_o(fault_cnt_o), .fault_cnt_clr_i(fault_cnt_clr_i),
`endif
    .flush_i(flush_i), .flush_done_o(flush_done_o), .fifo_count_o(fifo_count_o)
  );

  always #5 clk_i = ~clk_i;

  logic [3:0]  mode_v [4];
  logic [63:0] spa_v  [4];
  logic [7:0]  tag_v  [4];

  always_comb begin
    req_mode_i = '0;
    req_spa_i  = '0;
    req_tag_i  = '0;
    for (int c = 0; c < 4; c++) begin
      req_mode_i[c*4 +: 4]  = mode_v[c];
      req_spa_i[c*64 +: 64] = spa_v[c];
      req_tag_i[c*8 +: 8]   = tag_v[c];
    end
  end

  typedef struct packed {
    logic [63:0] spa;
    logic [3:0]  mode;
    logic [7:0]  tag;
    logic [1:0]  chan;
    logic        walk;
    logic        fault;
  } ent_t;

  typedef struct {
    int          ch;
    logic [3:0]  mode;
    logic [63:0] spa;
    logic [7:0]  tag;
    logic        walk;
    logic        fault;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  ent_t exp_q[$];
  int   m_rr, m_cnt;
  logic m_fd;
  int   m_fc;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic model_fault(logic [3:0] mode, logic [63:0] spa);
    if (mode == 4'd1) return (spa >> 43) != 64'd0;
    if (mode == 4'd2) return (spa >> 52) != 64'd0;
    if (mode == 4'd3) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: settle, check against the model, score pops, advance model, land at posedge+1.
  task automatic cycle();
    int       g;
    bit       found, acc, pop;
    logic [3:0] exp_ready;
    ent_t     e, h;
    #1;
    found = 0; g = 0;
    for (int i = 0; i < 4; i++) begin
      int c;
      c = (m_rr + i) % 4;
      if (!found && req_valid_i[c]) begin found = 1; g = c; end
    end
    exp_ready = (found && m_cnt < 4 && !flush_i && !rst_i) ? 4'(1 << g) : 4'd0;
    chk("req_ready", 64'(req_ready_o), 64'(exp_ready));
    chk("fifo_count", 64'(fifo_count_o), 64'(m_cnt));
    chk("out_valid", 64'(out_valid_o), 64'(m_cnt != 0));
    chk("flush_done", 64'(flush_done_o), 64'(m_fd));
`ifdef MPT_FETCH_FAULT_CNT_EN
    chk("fault_cnt", 64'(fault_cnt_o), 64'(m_fc));
`endif
    acc = (exp_ready != 0);
    pop = (m_cnt > 0) && out_ready_i && !flush_i && !rst_i;
    if (pop) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underflow got pop expected none");
      end else begin
        h = exp_q.pop_front();
        chk("head_spa", out_spa_o, h.spa);
        chk("head_mode", 64'(out_mode_o), 64'(h.mode));
        chk("head_tag", 64'(out_tag_o), 64'(h.tag));
        chk("head_chan", 64'(out_chan_o), 64'(h.chan));
        chk("head_walk", 64'(out_walk_o), 64'(h.walk));
        chk("head_fault", 64'(out_fault_o), 64'(h.fault));
      end
    end
    if (rst_i) begin
      m_cnt = 0; m_rr = 0; m_fd = 0; m_fc = 0; exp_q.delete();
    end else begin
`ifdef MPT_FETCH_FAULT_CNT_EN
      if (fault_cnt_clr_i) m_fc = 0;
      else if (acc && model_fault(mode_v[g], spa_v[g]) && m_fc != 16'hFFFF) m_fc++;
`endif
      if (flush_i) begin
        m_cnt = 0; m_rr = 0; exp_q.delete();
      end else begin
        if (acc) begin
          e.spa = spa_v[g]; e.mode = mode_v[g]; e.tag = tag_v[g]; e.chan = 2'(g);
          e.fault = model_fault(mode_v[g], spa_v[g]);
          e.walk = !e.fault;
          exp_q.push_back(e);
          m_rr = (g + 1) % 4;
        end
        m_cnt = m_cnt + int'(acc) - int'(pop);
      end
      m_fd = flush_i;
    end
    @(posedge clk_i);
    #1;
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{0, 4'd1,  64'h0000_03FF_FFFF_F000, 8'h5A, 1'b1, 1'b0};
    tbl[1]  = '{1, 4'd1,  64'h0000_0800_0000_0000, 8'h11, 1'b0, 1'b1};
    tbl[2]  = '{1, 4'd1,  64'h0000_07FF_FFFF_FFFF, 8'h12, 1'b1, 1'b0};
    tbl[3]  = '{1, 4'd2,  64'h0010_0000_0000_0000, 8'h13, 1'b0, 1'b1};
    tbl[4]  = '{1, 4'd2,  64'h000F_FFFF_FFFF_FFFF, 8'h14, 1'b1, 1'b0};
    tbl[5]  = '{1, 4'd0,  64'h0000_0000_0000_1000, 8'h15, 1'b0, 1'b1};
    tbl[6]  = '{1, 4'd7,  64'h0000_0000_0000_0000, 8'h16, 1'b0, 1'b1};
    tbl[7]  = '{1, 4'd3,  64'hFFFF_FFFF_FFFF_FFFF, 8'h17, 1'b1, 1'b0};
    tbl[8]  = '{3, 4'd15, 64'h0000_0000_0000_0000, 8'h18, 1'b0, 1'b1};
    tbl[9]  = '{2, 4'd3,  64'h0000_0000_0000_0000, 8'h19, 1'b1, 1'b0};
    tbl[10] = '{2, 4'd1,  64'h8000_0000_0000_0000, 8'h1A, 1'b0, 1'b1};

    rst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0; req_valid_i = 4'd0;
`ifdef MPT_FETCH_FAULT_CNT_EN
    fault_cnt_clr_i = 1'b0;
`endif
    for (int c = 0; c < 4; c++) begin
      mode_v[c] = 4'd3; spa_v[c] = 64'h1000 * (c + 1); tag_v[c] = 8'(8'hA0 + c);
    end
    m_rr = 0; m_cnt = 0; m_fd = 0; m_fc = 0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_count", 64'(fifo_count_o), 64'd0);
    chk("rst_spa", out_spa_o, 64'd0);
    chk("rst_walk", 64'(out_walk_o), 64'd0);
    chk("rst_flush_done", 64'(flush_done_o), 64'd0);

    // Format-check vector table: one request each, head checked the cycle after accept.
    out_ready_i = 1'b1;
    for (int k = 0; k < 11; k++) begin
      mode_v[tbl[k].ch] = tbl[k].mode;
      spa_v[tbl[k].ch]  = tbl[k].spa;
      tag_v[tbl[k].ch]  = tbl[k].tag;
      req_valid_i = 4'(1 << tbl[k].ch);
      cycle();
      req_valid_i = 4'd0;
      chk($sformatf("tbl%0d_valid", k), 64'(out_valid_o), 64'd1);
      chk($sformatf("tbl%0d_walk", k), 64'(out_walk_o), 64'(tbl[k].walk));
      chk($sformatf("tbl%0d_fault", k), 64'(out_fault_o), 64'(tbl[k].fault));
      chk($sformatf("tbl%0d_chan", k), 64'(out_chan_o), 64'(tbl[k].ch));
      chk($sformatf("tbl%0d_tag", k), 64'(out_tag_o), 64'(tbl[k].tag));
      cycle();
    end
    for (int c = 0; c < 4; c++) begin
      mode_v[c] = 4'd3; spa_v[c] = 64'h1000 * (c + 1); tag_v[c] = 8'(8'hA0 + c);
    end

    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;

    // Round robin with every channel requesting.
    req_valid_i = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_seq", 64'(req_ready_o), 64'(1 << (k % 4)));
      cycle();
    end
    req_valid_i = 4'b0001;
    cycle();
    req_valid_i = 4'b0101;
    #1;
    chk("rr_from1_first", 64'(req_ready_o), 64'b0100);
    cycle();
    #1;
    chk("rr_from1_second", 64'(req_ready_o), 64'b0001);
    cycle();
    req_valid_i = 4'd0;
    repeat (2) cycle();

    // Backpressure to full, single pop, refill.
    out_ready_i = 1'b0;
    req_valid_i = 4'b0001;
    repeat (6) cycle();
    #1;
    chk("full_count", 64'(fifo_count_o), 64'd4);
    chk("full_ready", 64'(req_ready_o), 64'd0);
    out_ready_i = 1'b1;
    cycle();
    out_ready_i = 1'b0;
    #1;
    chk("pop_no_bypass_count", 64'(fifo_count_o), 64'd3);
    cycle();
    #1;
    chk("refill_count", 64'(fifo_count_o), 64'd4);

    // Flush at count 3 with a pending pop and request.
    req_valid_i = 4'd0;
    out_ready_i = 1'b1;
    cycle();
    flush_i = 1'b1;
    req_valid_i = 4'b0001;
    #1;
    chk("flush_ready", 64'(req_ready_o), 64'd0);
    chk("flush_pre_count", 64'(fifo_count_o), 64'd3);
    cycle();
    flush_i = 1'b0;
    req_valid_i = 4'hF;
    #1;
    chk("flush_count", 64'(fifo_count_o), 64'd0);
    chk("flush_valid", 64'(out_valid_o), 64'd0);
    chk("flush_done_pulse", 64'(flush_done_o), 64'd1);
    chk("flush_rr0", 64'(req_ready_o), 64'b0001);
    cycle();
    req_valid_i = 4'd0;
    flush_i = 1'b1;
    repeat (3) cycle();
    flush_i = 1'b0;
    repeat (2) cycle();

`ifdef MPT_FETCH_FAULT_CNT_EN
    mode_v[1] = 4'd0;
    req_valid_i = 4'b0010;
    repeat (3) cycle();
    #1;
    chk("fcnt_three", 64'(fault_cnt_o), 64'd3);
    fault_cnt_clr_i = 1'b1;
    cycle();
    fault_cnt_clr_i = 1'b0;
    #1;
    chk("fcnt_clr_wins", 64'(fault_cnt_o), 64'd0);
    req_valid_i = 4'd0;
    mode_v[1] = 4'd3;
    repeat (2) cycle();
`endif

    // Reset with a full FIFO.
    out_ready_i = 1'b0;
    req_valid_i = 4'b0100;
    repeat (5) cycle();
    req_valid_i = 4'd0;
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    #1;
    chk("mrst_count", 64'(fifo_count_o), 64'd0);
    chk("mrst_valid", 64'(out_valid_o), 64'd0);
    chk("mrst_spa", out_spa_o, 64'd0);
    chk("mrst_tag", 64'(out_tag_o), 64'd0);
    chk("mrst_chan", 64'(out_chan_o), 64'd0);
    chk("mrst_mode", 64'(out_mode_o), 64'd0);
    chk("mrst_walk_fault", 64'({out_walk_o, out_fault_o}), 64'd0);
    chk("mrst_ready", 64'(req_ready_o), 64'd0);
`ifdef MPT_FETCH_FAULT_CNT_EN
    chk("mrst_fcnt", 64'(fault_cnt_o), 64'd0);
`endif
    req_valid_i = 4'b1000;
    out_ready_i = 1'b1;
    cycle();
    req_valid_i = 4'd0;
    repeat (2) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpt_fetch_arbiter.md
Name: mpt_fetch_arbiter

Overview:
Multi-channel successor to the single-port MPT walker fetch stage. It accepts walk requests from NUM_CH requestors, round-robin arbitrates among them, and format-checks the SPA against the MMPT mode. Checked transactions are buffered in a DEPTH-entry FIFO feeding the MPT walker pipeline. Each entry carries a walk/skip decision, a fault cause and the originating channel; the block also supports flush with a completion handshake.

Parameters:
NUM_CH, 4, number of requestor channels (1..16)
DEPTH, 4, output FIFO entries (power of two, >=2)
TAG_W, 8, opaque per-request tag width, forwarded unchanged
CH_W, $clog2(NUM_CH) (min 1), channel index width (derived, not overridable)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  NUM_CH  per-channel request valid
req_ready_o  out  NUM_CH  per-channel accept; one-hot or zero
req_mode_i  in  NUM_CH*4  per-channel MMPT.MODE (channel c at [4c+3:4c])
req_spa_i  in  NUM_CH*64  per-channel SPA
req_tag_i  in  NUM_CH*TAG_W  per-channel tag
out_valid_o  out  1  FIFO head valid
out_ready_i  in  1  downstream accepts head
out_spa_o  out  64  head SPA
out_mode_o  out  4  head mode
out_tag_o  out  TAG_W  head tag
out_chan_o  out  CH_W  head originating channel
out_walk_o  out  1  1 = MPT_WALKING_DO, 0 = MPT_WALKING_SKIP
out_fault_o  out  1  1 = NOT_VALID_ADDR, 0 = NO_ERROR
flush_i  in  1  flush request (level, sampled each cycle)
flush_done_o  out  1  one-cycle pulse, cycle after flush applied
fifo_count_o  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst_i high at a clock edge): FIFO empty, rr_ptr=0, all outputs 0, fault counter 0 (if enabled). Reset overrides flush and all traffic.
- Mode encoding: 0 BARE, 1 SMMPT43, 2 SMMPT52, 3 SMMPT64, 4..15 reserved.
- Format check (combinational, on granted channel):
  - BARE → fault.
  - SMMPT43 → fault if spa[63:43] != 0.
  - SMMPT52 → fault if spa[63:52] != 0.
  - SMMPT64 → no fault.
  - Reserved → fault.
  - walk = !fault.
- Arbitration: grant = first c with req_valid_i[c], scanning from rr_ptr upward with wrap modulo NUM_CH.
  - req_ready_o[grant]=1 iff FIFO not full and flush_i low; all other ready bits 0.
  - Accept = valid & ready. On accept, rr_ptr <= (grant+1) mod NUM_CH; otherwise rr_ptr holds.
- No full-bypass: when full, no accept even if out_ready_i pops the same cycle.
- Latency: accepted request appears at out_* the next cycle when FIFO was empty; FIFO order is strict accept order.
- Pop = out_valid_o & out_ready_i. Simultaneous push and pop leaves count unchanged.
- out_* reflect the head entry. Entry fields are undefined when out_valid_o=0, but driven 0 after reset.
- Requestor obligation: hold valid and payload until accepted. Dropping valid before accept is allowed; the request is simply not taken.
- Flush: while flush_i=1, no accept.
  - At the edge: FIFO emptied (count 0, out_valid_o 0 next cycle), rr_ptr <= 0.
  - Flush overrides a pop in the same cycle.
  - flush_done_o=1 in the cycle following each cycle where flush_i was sampled high.
  - Holding flush_i for N cycles gives N pulses.
- fifo_count_o ranges 0..DEPTH. Pointers wrap modulo DEPTH, using an extra MSB for full/empty.

Optional Feature:
Macro MPT_FETCH_FAULT_CNT_EN.
- Defined: adds ports fault_cnt_o (out, 16) and fault_cnt_clr_i (in, 1).
  - Counter increments on each accepted request with fault=1, saturating at 16'hFFFF.
  - clr synchronously zeroes it; clr wins over a same-cycle increment.
  - Reset clears it; flush does not affect it.
- Undefined: ports and counter absent; all other behaviour identical.

Test Plan:
- Single-channel legal request: ch0, mode=1, spa=0x0000_03FF_FFFF_F000, tag=0x5A → next cycle out_valid=1, walk=1, fault=0, chan=0, tag=0x5A.
- Format faults: ch1 mode=1 spa bit43 set; ch1 mode=2 spa bit52 set; ch1 mode=0; ch1 mode=7 → each emitted with walk=0, fault=1; mode=3 spa=all-ones → walk=1, fault=0.
- Round-robin fairness: NUM_CH=4, all valid continuously, out_ready=1 → grant sequence 0,1,2,3,0,...; with only ch2 and ch0 valid from rr_ptr=1 → 2 then 0.
- Backpressure/full: out_ready=0, DEPTH=4, ch0 always valid → 4 accepts, then req_ready=0, count=4. One cycle out_ready=1 → pop and no same-cycle push, count=3, then refill to 4.
- Flush mid-traffic: count=3 with out_ready=1 and flush_i=1 for one cycle → no pop recorded, no accept. Next cycle: count=0, out_valid=0, flush_done=1, rr_ptr=0 (next grant from ch0).
- Reset mid-operation plus counter (MPT_FETCH_FAULT_CNT_EN): 3 faulty accepts → fault_cnt=3; clr together with a faulty accept → 0; rst_i with a full FIFO → all outputs 0 next cycle.
